// File: rtl/slave_pkg.sv
// slave_pkg: shared types and constants for the I2C slave byte controller.
//   slave_state_e : protocol FSM states
//   ByteWidth     : bits per I2C byte
//   GenCallAddr   : general-call address byte (used with SLAVE_GENERAL_CALL_EN)
//   addr_match()  : compares the 7 address bits of a received address byte
package slave_pkg;

  localparam int unsigned ByteWidth = 8;

  localparam logic [ByteWidth-1:0] GenCallAddr = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRx,
    StRxAck,
    StTx,
    StTxAck
  } slave_state_e;

  // addr_byte[0] is the R/W bit and is not part of the address.
  function automatic logic addr_match(input logic [ByteWidth-1:0] addr_byte,
                                      input logic [6:0]           own_addr);
    return addr_byte[ByteWidth-1:1] == own_addr;
  endfunction

endpackage

// File: rtl/slave_sync_edge.sv
// slave_sync_edge: N-stage synchronizer with rise/fall detection on the synchronized level.
// Ports:
//   slave_clock  in  oversampling clock
//   slave_rst    in  asynchronous active-low reset
//   async_in     in  raw asynchronous input
//   sync_out     out synchronized level (last synchronizer stage)
//   rise         out 1 when sync_out is 1 and was 0 the previous cycle
//   fall         out 1 when sync_out is 0 and was 1 the previous cycle
// Stages must be >= 2; ResetVal is the reset value of every stage.
module slave_sync_edge
  import slave_pkg::*;
#(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic slave_clock,
  input  logic slave_rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge slave_clock or negedge slave_rst) begin
    if (!slave_rst) begin
      sync_q <= {Stages{ResetVal}};
      dly_q  <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], async_in};
      dly_q  <= sync_q[Stages-1];
    end
  end

  assign sync_out = sync_q[Stages-1];
  assign rise     = sync_q[Stages-1] & ~dly_q;
  assign fall     = ~sync_q[Stages-1] & dly_q;

endmodule

// File: rtl/slave_byte_ctrl.sv
// slave_byte_ctrl: I2C slave protocol controller, downstream of the start/stop detector.
// Oversamples SCL/SDA on slave_clock, decodes the address byte, ACKs on a match and then
// receives write bytes or serves read bytes through the open-drain enable slave_sda_oe.
// Ports:
//   slave_clock              in   oversampling clock (>= 8x SCL)
//   slave_rst                in   asynchronous active-low reset
//   slave_scl_in/sda_in      in   raw bus SCL / SDA
//   slave_start_stop_detect  in   level from the start/stop detector (any change = bus event)
//   slave_sda_oe             out  1 = pull SDA low
//   slave_rw                 out  R/W bit of the current transfer (1 = read)
//   slave_busy               out  1 while addressed (state other than IDLE/ADDR)
//   slave_rx_data/rx_valid   out  last written byte / 1-cycle update pulse
//   slave_tx_req             out  1-cycle request; slave_tx_data is sampled in that cycle
//   slave_tx_data            in   read byte
//   slave_gc                 out  general-call transfer in progress (only with
//                                 SLAVE_GENERAL_CALL_EN defined)
// Optional feature macro: SLAVE_GENERAL_CALL_EN (address byte 8'h00 also matches, rw forced 0).
module slave_byte_ctrl
  import slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 slave_clock,
  input  logic                 slave_rst,
  input  logic                 slave_scl_in,
  input  logic                 slave_sda_in,
  input  logic                 slave_start_stop_detect,
  output logic                 slave_sda_oe,
  output logic                 slave_rw,
  output logic                 slave_busy,
  output logic [ByteWidth-1:0] slave_rx_data,
  output logic                 slave_rx_valid,
  output logic                 slave_tx_req,
  input  logic [ByteWidth-1:0] slave_tx_data
`ifdef SLAVE_GENERAL_CALL_EN
  ,
  output logic                 slave_gc
`endif
);

  // Fewer than two stages would not be a synchronizer at all.
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic ssd_s, ssd_rise, ssd_fall;

  slave_sync_edge #(
    .Stages   (Stages),
    .ResetVal (1'b1)
  ) u_sync_scl (
    .slave_clock (slave_clock),
    .slave_rst   (slave_rst),
    .async_in    (slave_scl_in),
    .sync_out    (scl_s),
    .rise        (scl_rise),
    .fall        (scl_fall)
  );

  slave_sync_edge #(
    .Stages   (Stages),
    .ResetVal (1'b1)
  ) u_sync_sda (
    .slave_clock (slave_clock),
    .slave_rst   (slave_rst),
    .async_in    (slave_sda_in),
    .sync_out    (sda_s),
    .rise        (sda_rise),
    .fall        (sda_fall)
  );

  slave_sync_edge #(
    .Stages   (Stages),
    .ResetVal (1'b0)
  ) u_sync_ssd (
    .slave_clock (slave_clock),
    .slave_rst   (slave_rst),
    .async_in    (slave_start_stop_detect),
    .sync_out    (ssd_s),
    .rise        (ssd_rise),
    .fall        (ssd_fall)
  );

  // SDA edges and the detector level itself are not needed, only its transitions.
  logic unused_sync;
  assign unused_sync = sda_rise | sda_fall | ssd_s;

  // Bus events: detector output changed while SCL high; SDA level tells START from STOP.
  logic bus_event, ev_start, ev_stop;
  assign bus_event = (ssd_rise | ssd_fall) & scl_s;
  assign ev_start  = bus_event & ~sda_s;
  assign ev_stop   = bus_event & sda_s;

  slave_state_e         state_q;
  logic [2:0]           bit_cnt_q;
  logic                 byte_full_q;  // 8th bit sampled, act on the following SCL fall
  logic                 ack_ok_q;     // master ACK seen in TX_ACK
  logic [ByteWidth-1:0] shift_q;
  logic                 sda_oe_q;
  logic                 rw_q;
  logic                 gc_q;
  logic [ByteWidth-1:0] rx_data_q;
  logic                 rx_valid_q;

  logic addr_hit, addr_gc;
  assign addr_hit = addr_match(shift_q, SLAVE_ADDR);
`ifdef SLAVE_GENERAL_CALL_EN
  assign addr_gc  = (shift_q == GenCallAddr);
`else
  assign addr_gc  = 1'b0;
`endif

  // tx_req is combinational so the byte is sampled in the very cycle the request is high,
  // the same cycle that loads it into the shift register.
  logic tx_load;
  assign tx_load = scl_fall & ~bus_event &
                   (((state_q == StAddrAck) & rw_q) | ((state_q == StTxAck) & ack_ok_q));

  always_ff @(posedge slave_clock or negedge slave_rst) begin
    if (!slave_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_full_q <= 1'b0;
      ack_ok_q    <= 1'b0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      gc_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (ev_start) begin
        state_q     <= StAddr;
        bit_cnt_q   <= 3'd0;
        byte_full_q <= 1'b0;
        ack_ok_q    <= 1'b0;
        sda_oe_q    <= 1'b0;
        gc_q        <= 1'b0;
      end else if (ev_stop) begin
        state_q     <= StIdle;
        bit_cnt_q   <= 3'd0;
        byte_full_q <= 1'b0;
        ack_ok_q    <= 1'b0;
        sda_oe_q    <= 1'b0;
        gc_q        <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            sda_oe_q <= 1'b0;
          end

          StAddr, StRx: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[ByteWidth-2:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
            end else if (scl_fall && byte_full_q) begin
              byte_full_q <= 1'b0;
              if (state_q == StAddr) begin
                if (addr_gc || addr_hit) begin
                  rw_q     <= addr_gc ? 1'b0 : shift_q[0];
                  gc_q     <= addr_gc;
                  sda_oe_q <= 1'b1;
                  state_q  <= StAddrAck;
                end else begin
                  state_q <= StIdle;
                end
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                sda_oe_q   <= 1'b1;
                state_q    <= StRxAck;
              end
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              if (rw_q) begin
                shift_q  <= slave_tx_data;
                sda_oe_q <= ~slave_tx_data[ByteWidth-1];
                state_q  <= StTx;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= StRx;
              end
            end
          end

          StRxAck: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              sda_oe_q  <= 1'b0;
              state_q   <= StRx;
            end
          end

          // MSB is already on the bus when TX is entered; each fall presents the next bit.
          StTx: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
            end else if (scl_fall) begin
              if (byte_full_q) begin
                byte_full_q <= 1'b0;
                ack_ok_q    <= 1'b0;
                sda_oe_q    <= 1'b0;
                state_q     <= StTxAck;
              end else begin
                shift_q  <= {shift_q[ByteWidth-2:0], 1'b0};
                sda_oe_q <= ~shift_q[ByteWidth-2];
              end
            end
          end

          StTxAck: begin
            if (scl_rise) begin
              if (sda_s) state_q  <= StIdle;
              else       ack_ok_q <= 1'b1;
            end else if (scl_fall && ack_ok_q) begin
              ack_ok_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              shift_q   <= slave_tx_data;
              sda_oe_q  <= ~slave_tx_data[ByteWidth-1];
              state_q   <= StTx;
            end
          end

          default: begin
            sda_oe_q <= 1'b0;
            state_q  <= StIdle;
          end
        endcase
      end
    end
  end

  assign slave_sda_oe   = sda_oe_q;
  assign slave_rw       = rw_q;
  assign slave_busy     = (state_q != StIdle) && (state_q != StAddr);
  assign slave_rx_data  = rx_data_q;
  assign slave_rx_valid = rx_valid_q;
  assign slave_tx_req   = tx_load;

`ifdef SLAVE_GENERAL_CALL_EN
  assign slave_gc = gc_q;
`else
  logic unused_gc;
  assign unused_gc = gc_q;
`endif

endmodule

// File: tb/tb_slave_byte_ctrl.sv
// Directed bench for slave_byte_ctrl: a bus-master model drives SCL/SDA and toggles the
// start/stop detector level at every START/STOP; open-drain SDA is master & ~slave_sda_oe.
module tb_slave_byte_ctrl;
  import slave_pkg::*;

  localparam int Q = 60;  // quarter SCL period (6 slave_clock cycles)

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl     = 1'b1;
  logic       m_sda   = 1'b1;
  logic       ssd     = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       sda_oe, rw, busy, rx_valid, tx_req;
  logic [7:0] rx_data;
`ifdef SLAVE_GENERAL_CALL_EN
  logic       gc;
`endif

  wire sda_bus = m_sda & ~sda_oe;

  slave_byte_ctrl dut (
    .slave_clock             (clk),
    .slave_rst               (rst_n),
    .slave_scl_in            (scl),
    .slave_sda_in            (sda_bus),
    .slave_start_stop_detect (ssd),
    .slave_sda_oe            (sda_oe),
    .slave_rw                (rw),
    .slave_busy              (busy),
    .slave_rx_data           (rx_data),
    .slave_rx_valid          (rx_valid),
    .slave_tx_req            (tx_req),
    .slave_tx_data           (tx_data)
`ifdef SLAVE_GENERAL_CALL_EN
    ,
    .slave_gc                (gc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int rx_pulses = 0;
  int tx_pulses = 0;
  int oe_cycles = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (tx_req)   tx_pulses++;
    if (sda_oe)   oe_cycles++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus-master primitives; each ends with SCL low except bus_stop (SCL high).
  task automatic bus_start();
    #Q; m_sda = 1'b0; ssd = ~ssd;
    #Q; scl = 1'b0;
  endtask

  task automatic bus_restart();
    #Q; m_sda = 1'b1;
    #Q; scl = 1'b1;
    #Q; m_sda = 1'b0; ssd = ~ssd;
    #Q; scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q; m_sda = 1'b0;
    #Q; scl = 1'b1;
    #Q; m_sda = 1'b1; ssd = ~ssd;
    #Q;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    #Q; m_sda = b;
    #Q; scl = 1'b1;
    #Q; s = sda_bus;
    #Q; scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         r0, t0, o0;

    // Reset state
    #13;
    check("rst_oe", 8'(sda_oe), 8'h0);
    check("rst_rw", 8'(rw), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", 8'(rx_valid), 8'h0);
    check("rst_tx_req", 8'(tx_req), 8'h0);
    #10 rst_n = 1'b1;

    // Write 0xA5 to 0x50
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", 8'(ack), 8'h0);
    check("wr_busy", 8'(busy), 8'h1);
    write_byte(8'hA5, ack);
    check("wr_data_ack", 8'(ack), 8'h0);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rx_pulses", 8'(rx_pulses - r0), 8'd1);
    bus_stop();
    #Q;
    check("wr_busy_after_stop", 8'(busy), 8'h0);
    check("wr_oe_after_stop", 8'(sda_oe), 8'h0);

    // Address 0x51: no match
    r0 = rx_pulses;
    o0 = oe_cycles;
    bus_start();
    d = 8'hA2;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    #40;
    check("mm_state_idle", 8'(dut.state_q), 8'(StIdle));
    clock_bit(1'b1, ack);
    check("mm_nack", 8'(ack), 8'h1);
    bus_stop();
    check("mm_oe_never", 8'(oe_cycles - o0), 8'd0);
    check("mm_rx_pulses", 8'(rx_pulses - r0), 8'd0);

    // Read 0x3C (ACK) then 0xC3 (NACK) from 0x50
    t0 = tx_pulses;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 8'(ack), 8'h0);
    check("rd_rw", 8'(rw), 8'h1);
    read_byte(d);
    check("rd_byte0", d, 8'h3C);
    tx_data = 8'hC3;
    clock_bit(1'b0, s);
    read_byte(d);
    check("rd_byte1", d, 8'hC3);
    clock_bit(1'b1, s);
    #40;
    check("rd_oe_after_nack", 8'(sda_oe), 8'h0);
    check("rd_busy_after_nack", 8'(busy), 8'h0);
    check("rd_tx_pulses", 8'(tx_pulses - t0), 8'd2);
    bus_stop();

    // Repeated START: write address, then restart as read
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_wr_ack", 8'(ack), 8'h0);
    check("rs_rw_write", 8'(rw), 8'h0);
    tx_data = 8'h5A;
    bus_restart();
    write_byte(8'hA1, ack);
    check("rs_rd_ack", 8'(ack), 8'h0);
    check("rs_rw_read", 8'(rw), 8'h1);
    read_byte(d);
    check("rs_rd_byte", d, 8'h5A);
    clock_bit(1'b1, s);
    bus_stop();
    check("rs_rx_pulses", 8'(rx_pulses - r0), 8'd0);

    // STOP after 4 data bits
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    check("ms_addr_ack", 8'(ack), 8'h0);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    bus_stop();
    check("ms_state_idle", 8'(dut.state_q), 8'(StIdle));
    check("ms_busy", 8'(busy), 8'h0);
    check("ms_oe", 8'(sda_oe), 8'h0);
    check("ms_rx_data", rx_data, 8'hA5);
    check("ms_rx_pulses", 8'(rx_pulses - r0), 8'd0);

    // Reset during ADDR_ACK with SCL low
    bus_start();
    d = 8'hA0;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    #40;
    check("ra_oe_before", 8'(sda_oe), 8'h1);
    check("ra_busy_before", 8'(busy), 8'h1);
    rst_n = 1'b0;
    #1;
    check("ra_oe", 8'(sda_oe), 8'h0);
    check("ra_busy", 8'(busy), 8'h0);
    check("ra_rw", 8'(rw), 8'h0);
    check("ra_rx_data", rx_data, 8'h00);
    check("ra_rx_valid", 8'(rx_valid), 8'h0);
    check("ra_tx_req", 8'(tx_req), 8'h0);
    #19 rst_n = 1'b1;
    #Q; m_sda = 1'b1;
    #Q; scl = 1'b1;
    r0 = rx_pulses;
    bus_start();
    write_byte(8'hA0, ack);
    check("ra_addr_ack", 8'(ack), 8'h0);
    write_byte(8'h3C, ack);
    check("ra_data_ack", 8'(ack), 8'h0);
    check("ra_rx_data_new", rx_data, 8'h3C);
    check("ra_rx_pulses", 8'(rx_pulses - r0), 8'd1);
    bus_stop();
    #Q;
    check("ra_busy_end", 8'(busy), 8'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/slave_byte_ctrl.md
Name: slave_byte_ctrl

Overview:
- I2C slave protocol controller. It sits directly downstream of the slave start/stop detector and consumes its start_stop_detect output together with raw SCL/SDA.
- Oversamples the bus on slave_clock. Shifts in the address byte and compares it to SLAVE_ADDR.
- On a match, ACKs and then either receives write bytes or serves read bytes, generating the SDA pull-down enable.
- Presents received bytes and read-data requests to the slave register file.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this slave answers to.
SYNC_STAGES, 2, synchronizer depth for SCL, SDA and start_stop_detect (minimum 2).

Ports:
slave_clock  in  1  oversampling clock; must be at least 8x SCL.
slave_rst  in  1  reset, asynchronous, active-low.
slave_scl_in  in  1  raw bus SCL.
slave_sda_in  in  1  raw bus SDA.
slave_start_stop_detect  in  1  level output of the start/stop detector.
slave_sda_oe  out  1  1 = pull SDA low (open-drain driver enable).
slave_rw  out  1  R/W bit of the current transfer (1 = read).
slave_busy  out  1  1 while addressed (any state other than IDLE or ADDR).
slave_rx_data  out  8  last byte received in a write transfer.
slave_rx_valid  out  1  1-cycle pulse when slave_rx_data updates.
slave_tx_req  out  1  1-cycle pulse requesting the next read byte.
slave_tx_data  in  8  read byte; sampled in the same cycle slave_tx_req is high.

Behaviour:
- Reset and asynchronous state
  - Asynchronous reset, active-low on slave_rst; clock slave_clock.
  - All outputs reset to 0. State resets to IDLE; bit counter, shift register and synchronizers reset to 0. Synchronizers for SCL/SDA reset to 1.
- Edge and event detection (synchronized signals)
  - SCL rise: scl_s==1 && scl_d==0.
  - SCL fall: scl_s==0 && scl_d==1.
  - Bus event: any change of the synchronized start_stop_detect while scl_s==1.
  - The event is a START if sda_s==0 and a STOP if sda_s==1.
- Event priority
  - START: from any state, go to ADDR, clear the bit counter and deassert slave_sda_oe in the same cycle. This covers repeated START.
  - STOP: from any state, go to IDLE and deassert slave_sda_oe.
  - A START or STOP overrides an SCL edge detected in the same cycle.
- Bit sampling
  - SDA is sampled into the shift register (MSB first) on SCL rise.
  - The bit counter is 3 bits and wraps 7->0. The byte is complete on the rise at count 7.
- States
  - IDLE: ignore SCL edges; slave_sda_oe=0.
  - ADDR: shift 8 bits. On the SCL fall after bit 8:
    - On match {shift[7:1]==SLAVE_ADDR}: latch slave_rw=shift[0], assert slave_sda_oe (ACK) and go to ADDR_ACK.
    - Otherwise: go to IDLE.
  - ADDR_ACK: on the next SCL fall, leave ACK as follows.
    - If rw=0: go to RX; slave_sda_oe=0.
    - If rw=1: pulse slave_tx_req, load slave_tx_data into the shift register and go to TX. slave_sda_oe=~tx_data[7] in that same cycle.
  - RX: shift 8 bits. On the SCL fall after bit 8:
    - slave_rx_data<=shift and slave_rx_valid pulses for 1 cycle.
    - Assert slave_sda_oe and go to RX_ACK.
  - RX_ACK: on the next SCL fall, slave_sda_oe=0 and go to RX.
  - TX: on each SCL fall, shift left and drive slave_sda_oe=~next bit. On the SCL fall after the 8th bit, slave_sda_oe=0 (release for master ACK) and go to TX_ACK.
  - TX_ACK: sample SDA on SCL rise.
    - If 0 (ACK): on the next SCL fall, pulse tx_req, load a byte and go to TX.
    - If 1 (NACK): go to IDLE (wait for STOP/START).
- Latency: SCL/SDA edge to action is SYNC_STAGES+1 slave_clock cycles.
- slave_sda_oe changes only on SCL fall or on a bus event, never while SCL is high otherwise.

Optional Feature:
- Macro SLAVE_GENERAL_CALL_EN.
- Defined: address byte 8'h00 is also a match. It forces rw=0 and additionally asserts an internal gc flag, exported on output slave_gc (1 while in a general-call transfer, 0 otherwise).
- Undefined: 8'h00 is treated as a mismatch and the slave_gc port is absent.

Decomposition:
- Shared package slave_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK);
  - constant for the byte width, 8;
  - general-call address 8'h00.
- One sub-module, slave_sync_edge: an N-stage synchronizer plus rise/fall detector, instantiated for SCL, SDA and start_stop_detect.

Test Plan:
- Write to address 0x50, data 0xA5, STOP -> ACK low during both 9th clocks; slave_rx_data=0xA5 with one rx_valid pulse; busy 0 after STOP.
- Address 0x51 (mismatch) -> slave_sda_oe never asserted; no rx_valid; state back to IDLE after 8th bit.
- Read from 0x50 with tx_data 0x3C then 0xC3, master ACKs the first and NACKs the second -> SDA bits 00111100 then 11000011; exactly two tx_req pulses; slave_sda_oe=0 after NACK.
- Repeated START after the write address byte, then read -> controller restarts in ADDR; slave_rw goes 0->1; no spurious rx_valid.
- STOP in mid-byte (after 4 data bits) -> IDLE immediately; slave_sda_oe=0; slave_rx_data unchanged.
- Assert slave_rst low during ADDR_ACK with SCL low -> slave_sda_oe drops within the same cycle; all outputs 0; next START is handled normally.
